// File: rtl/rv32_pkg.sv
// Shared types and constants for the rv32_top multi-cycle RV32I core.
package rv32_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned MEM_DEPTH = 16384;
    localparam int unsigned MEM_AW    = 14;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    // Data-memory request prepared in EX and presented in MEM
    typedef struct packed {
        logic                web;
        logic [XLEN-1:0]     bweb;
        logic [MEM_AW-1:0]   a;
        logic [XLEN-1:0]     di;
    } sram_req_t;

    function automatic logic [XLEN-1:0] alu_calc(input alu_op_e op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [XLEN-1:0] y;
        case (op)
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: y = XLEN'(a < b);
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = XLEN'($signed(a) >>> b[4:0]);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = a + b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/rv32_top_sram.sv
// Word-addressed 16K x 32 synchronous SRAM macro model and its wrapper.
module sram_macro (
    input  logic        clk,
    input  logic        CEB,
    input  logic        WEB,
    input  logic [31:0] BWEB,
    input  logic [13:0] A,
    input  logic [31:0] DI,
    output logic [31:0] DO
);
    logic [31:0] MEMORY [0:511][0:31];

    // Read-before-write; BWEB bit low selects DI for that bit
    always_ff @(posedge clk) begin
        if (!CEB) begin
            DO <= MEMORY[A[13:5]][A[4:0]];
            if (!WEB) begin
                MEMORY[A[13:5]][A[4:0]] <= (MEMORY[A[13:5]][A[4:0]] & BWEB) | (DI & ~BWEB);
            end
        end
    end
endmodule

module SRAM_wrapper (
    input  logic        clk,
    input  logic        CEB,
    input  logic        WEB,
    input  logic [31:0] BWEB,
    input  logic [13:0] A,
    input  logic [31:0] DI,
    output logic [31:0] DO
);
    sram_macro i_SRAM (
        .clk  (clk),
        .CEB  (CEB),
        .WEB  (WEB),
        .BWEB (BWEB),
        .A    (A),
        .DI   (DI),
        .DO   (DO)
    );
endmodule

// File: rtl/rv32_top.sv
// Multi-cycle RV32I core: IF/ID/EX/MEM/WB sequencer with separate instruction and data SRAMs.
module rv32_top
    import rv32_pkg::*;
(
    input logic clk,
    input logic rst
);
    state_e          state, state_nx;
    logic [31:0]     pc, ir, rs1_v, rs2_v, res, npc;
    logic [1:0]      lane;
    logic [31:0]     regs [32];
    logic [63:0]     cycle_cnt, instret_cnt;
    sram_req_t       dm_req, ex_req;
    logic [31:0]     im_do, dm_do;

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      f3;
    logic            f7b5;
    logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            is_load, is_store;
    logic [15:0]     ex_addr;
    alu_op_e         alu_sel;
    logic [31:0]     alu_y, csr_val, ex_res, ex_npc, ld_val, wb_val;
    logic            taken, rd_we, retire;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            im_ceb_c, dm_ceb_c;

    assign opcode  = ir[6:0];
    assign rd      = ir[11:7];
    assign f3      = ir[14:12];
    assign f7b5    = ir[30];
    assign imm_i   = {{20{ir[31]}}, ir[31:20]};
    assign imm_s   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u   = {ir[31:12], 12'b0};
    assign imm_j   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign ex_addr  = rs1_v[15:0] + (is_store ? imm_s[15:0] : imm_i[15:0]);

    // Memories are gated by rst so a reset edge never commits a write
    assign im_ceb_c = !((state == S_IF)  && rst);
    assign dm_ceb_c = !((state == S_MEM) && rst);

    SRAM_wrapper IM1 (
        .clk  (clk),
        .CEB  (im_ceb_c),
        .WEB  (1'b1),
        .BWEB ('1),
        .A    (pc[15:2]),
        .DI   ('0),
        .DO   (im_do)
    );

    SRAM_wrapper DM1 (
        .clk  (clk),
        .CEB  (dm_ceb_c),
        .WEB  (dm_req.web),
        .BWEB (dm_req.bweb),
        .A    (dm_req.a),
        .DI   (dm_req.di),
        .DO   (dm_do)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IF;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IF:    state_nx = S_ID;
            S_ID:    state_nx = S_EX;
            S_EX:    state_nx = (is_load || is_store) ? S_MEM : S_WB;
            S_MEM:   state_nx = is_load ? S_WB : S_IF;
            S_WB:    state_nx = S_IF;
            default: state_nx = S_IF;
        endcase
    end

    // ALU operation, branch compare and CSR read selection
    always_comb begin
        alu_sel = ALU_ADD;
        case (f3)
            3'b000:  alu_sel = (opcode == OP_OP && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
        alu_y = alu_calc(alu_sel, rs1_v, (opcode == OP_OP) ? rs2_v : imm_i);

        taken = 1'b0;
        case (f3)
            3'b000:  taken = (rs1_v == rs2_v);
            3'b001:  taken = (rs1_v != rs2_v);
            3'b100:  taken = ($signed(rs1_v) <  $signed(rs2_v));
            3'b101:  taken = ($signed(rs1_v) >= $signed(rs2_v));
            3'b110:  taken = (rs1_v <  rs2_v);
            3'b111:  taken = (rs1_v >= rs2_v);
            default: taken = 1'b0;
        endcase

        csr_val = '0;
        case (ir[31:20])
            CSR_CYCLE:    csr_val = cycle_cnt[31:0];
            CSR_CYCLEH:   csr_val = cycle_cnt[63:32];
            CSR_INSTRET:  csr_val = instret_cnt[31:0];
            CSR_INSTRETH: csr_val = instret_cnt[63:32];
            default:      csr_val = '0;
        endcase
    end

    // EX result, next PC and data-memory request
    always_comb begin
        ex_res = '0;
        ex_npc = pc + 32'd4;
        ex_req = '{web: 1'b1, bweb: '1, a: ex_addr[15:2], di: '0};
        case (opcode)
            OP_LUI:    ex_res = imm_u;
            OP_AUIPC:  ex_res = pc + imm_u;
            OP_JAL: begin
                ex_res = pc + 32'd4;
                ex_npc = pc + imm_j;
            end
            OP_JALR: begin
                ex_res = pc + 32'd4;
                ex_npc = (rs1_v + imm_i) & ~32'd1;
            end
            OP_BRANCH: if (taken) ex_npc = pc + imm_b;
            OP_IMM, OP_OP: ex_res = alu_y;
            OP_SYSTEM: ex_res = csr_val;
            OP_STORE: begin
                ex_req.web = 1'b0;
                case (f3[1:0])
                    2'b00: begin
                        ex_req.di   = {4{rs2_v[7:0]}};
                        ex_req.bweb = ~(32'h0000_00FF << {ex_addr[1:0], 3'b000});
                    end
                    2'b01: begin
                        ex_req.di   = {2{rs2_v[15:0]}};
                        ex_req.bweb = ex_addr[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
                    end
                    default: begin
                        ex_req.di   = rs2_v;
                        ex_req.bweb = '0;
                    end
                endcase
            end
            default: ex_res = '0;
        endcase
    end

    // Load lane extraction and writeback selection
    always_comb begin
        ld_byte = 8'(dm_do >> {lane, 3'b000});
        ld_half = lane[1] ? dm_do[31:16] : dm_do[15:0];
        case (f3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'b0, ld_byte};
            3'b101:  ld_val = {16'b0, ld_half};
            default: ld_val = dm_do;
        endcase
        wb_val = is_load ? ld_val : res;
        rd_we  = (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
                 (opcode == OP_JALR) || (opcode == OP_IMM) || (opcode == OP_OP) ||
                 is_load || ((opcode == OP_SYSTEM) && (f3 != 3'b000));
        retire = (state == S_WB) || ((state == S_MEM) && is_store);
    end

    // Datapath registers, register file and counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= '0;
            ir          <= '0;
            rs1_v       <= '0;
            rs2_v       <= '0;
            res         <= '0;
            npc         <= '0;
            lane        <= '0;
            dm_req      <= '{web: 1'b1, bweb: '1, a: '0, di: '0};
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (state == S_ID) begin
                ir    <= im_do;
                rs1_v <= regs[im_do[19:15]];
                rs2_v <= regs[im_do[24:20]];
            end
            if (state == S_EX) begin
                res    <= ex_res;
                npc    <= ex_npc;
                lane   <= ex_addr[1:0];
                dm_req <= ex_req;
            end
            if (retire) begin
                pc          <= npc;
                instret_cnt <= instret_cnt + 64'd1;
            end
            if ((state == S_WB) && rd_we && (rd != 5'd0)) regs[rd] <= wb_val;
        end
    end

endmodule

// File: tb/tb_rv32_top.sv
// Directed self-checking bench for rv32_top using back-door loaded program images.
module tb_rv32_top;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rv32_top dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input int op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [11:0] v;
        v = 12'(imm);
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [12:0] v;
        v = 13'(imm);
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
        return {20'(imm20), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] v;
        v = 21'(imm);
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
    endfunction

    function automatic logic [31:0] dm_word(input int w);
        return dut.DM1.i_SRAM.MEMORY[9'(w >> 5)][5'(w & 31)];
    endfunction

    task automatic poke(input int w, input logic [31:0] v);
        dut.IM1.i_SRAM.MEMORY[9'(w >> 5)][5'(w & 31)] <= v;
        dut.DM1.i_SRAM.MEMORY[9'(w >> 5)][5'(w & 31)] <= v;
    endtask

    task automatic clear_mem();
        for (int r = 0; r < 512; r++) begin
            for (int c = 0; c < 32; c++) begin
                dut.IM1.i_SRAM.MEMORY[9'(r)][5'(c)] <= '0;
                dut.DM1.i_SRAM.MEMORY[9'(r)][5'(c)] <= '0;
            end
        end
    endtask

    task automatic load_prog(input logic [31:0] prog [$]);
        rst = 1'b0;
        clear_mem();
        foreach (prog[i]) poke(i, prog[i]);
    endtask

    task automatic hold_reset_and_release();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] prog [$];
        logic [31:0] c0;
        logic [31:0] c1;
        int          waited;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        @(negedge clk);

        // Reset state and first instruction latency
        prog = '{enc_i(5, 0, 0, 1, 7'h13)};
        load_prog(prog);
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", dut.pc, 32'h0);
        check("rst_state", 32'(dut.state), 32'd0);
        check("rst_cycle", dut.cycle_cnt[31:0], 32'h0);
        check("rst_instret", dut.instret_cnt[31:0], 32'h0);
        rst = 1'b1;
        run(3);
        check("addi_not_yet", dut.regs[1], 32'h0);
        run(1);
        check("addi_x1", dut.regs[1], 32'd5);
        check("addi_pc", dut.pc, 32'd4);

        // Store / sub-word load round trip
        prog = '{
            enc_u(32'h8, 2, 7'h37),
            enc_u(32'h87654, 3, 7'h37),
            enc_i(32'h321, 3, 0, 3, 7'h13),
            enc_s(0, 3, 2, 2),
            enc_i(3, 2, 0, 4, 7'h03),
            enc_i(2, 2, 5, 5, 7'h03),
            enc_i(32'hAA, 0, 0, 6, 7'h13),
            enc_s(1, 6, 2, 0),
            enc_i(0, 2, 2, 7, 7'h03),
            enc_i(2, 2, 1, 8, 7'h03),
            enc_i(3, 2, 4, 9, 7'h03),
            enc_j(0, 0)
        };
        load_prog(prog);
        hold_reset_and_release();
        run(60);
        check("lb_sext", dut.regs[4], 32'hFFFF_FF87);
        check("lhu_zext", dut.regs[5], 32'h0000_8765);
        check("sb_word", dm_word(32'h2000), 32'h8765_AA21);
        check("lw_after_sb", dut.regs[7], 32'h8765_AA21);
        check("lh_sext", dut.regs[8], 32'hFFFF_8765);
        check("lbu_zext", dut.regs[9], 32'h0000_0087);
        check("selfloop_pc", dut.pc, 32'd44);

        // Signed vs unsigned branches and JALR bit0 clearing
        prog = '{
            enc_i(-1, 0, 0, 1, 7'h13),
            enc_i(1, 0, 0, 2, 7'h13),
            enc_b(8, 2, 1, 4),
            enc_i(1, 0, 0, 10, 7'h13),
            enc_b(8, 2, 1, 6),
            enc_i(2, 0, 0, 11, 7'h13),
            enc_i(32'h103, 0, 0, 12, 7'h13),
            enc_i(0, 12, 0, 13, 7'h67)
        };
        load_prog(prog);
        poke(32'h40, enc_j(0, 0));
        hold_reset_and_release();
        run(60);
        check("blt_taken", dut.regs[10], 32'h0);
        check("bltu_not_taken", dut.regs[11], 32'd2);
        check("jalr_link", dut.regs[13], 32'd32);
        check("jalr_target", dut.pc, 32'h102);

        // ALU mix, x0, counters and end-code store
        prog = '{
            enc_i(-8, 0, 0, 1, 7'h13),
            enc_i(32'h401, 1, 5, 2, 7'h13),
            enc_i(28, 1, 5, 3, 7'h13),
            enc_i(0, 1, 2, 4, 7'h13),
            enc_r(0, 3, 1, 3, 5),
            enc_r(32'h20, 1, 3, 0, 6),
            enc_i(7, 0, 0, 0, 7'h13),
            enc_i(32'hC00, 0, 2, 7, 7'h73),
            enc_i(32'hC00, 0, 2, 8, 7'h73),
            enc_i(32'hC02, 0, 2, 9, 7'h73),
            enc_i(32'hC02, 0, 2, 14, 7'h73),
            enc_i(32'hC80, 0, 2, 15, 7'h73),
            enc_u(32'h8, 16, 7'h37),
            enc_s(0, 6, 16, 2),
            enc_s(4, 2, 16, 2),
            enc_i(-1, 0, 0, 17, 7'h13),
            enc_s(-4, 17, 0, 2),
            enc_j(0, 0)
        };
        load_prog(prog);
        hold_reset_and_release();
        waited = 0;
        while (dm_word(32'h3FFF) != 32'hFFFF_FFFF && waited < 200) begin
            run(1);
            waited++;
        end
        check("end_code", dm_word(32'h3FFF), 32'hFFFF_FFFF);
        check("srai", dut.regs[2], 32'hFFFF_FFFC);
        check("srli", dut.regs[3], 32'h0000_000F);
        check("slti", dut.regs[4], 32'd1);
        check("sltu", dut.regs[5], 32'd0);
        check("x0_zero", dut.regs[0], 32'h0);
        check("res0", dm_word(32'h2000), 32'd23);
        check("res1", dm_word(32'h2001), 32'hFFFF_FFFC);
        c0 = dut.regs[7];
        c1 = dut.regs[8];
        check("rdcycle_abs", c0, 32'd30);
        check("rdcycle_delta", c1 - c0, 32'd4);
        check("rdinstret_abs", dut.regs[9], 32'd9);
        check("rdinstret_delta", dut.regs[14] - dut.regs[9], 32'd1);
        check("rdcycleh", dut.regs[15], 32'h0);

        // Reset landing on a store's MEM cycle
        prog = '{
            enc_i(32'h55, 0, 0, 1, 7'h13),
            enc_u(32'h8, 2, 7'h37),
            enc_s(0, 1, 2, 2)
        };
        load_prog(prog);
        poke(32'h2000, 32'h1234_5678);
        hold_reset_and_release();
        run(11);
        check("pre_rst_state", 32'(dut.state), 32'd3);
        check("pre_rst_x1", dut.regs[1], 32'h55);
        rst = 1'b0;
        run(1);
        check("rst_store_blocked", dm_word(32'h2000), 32'h1234_5678);
        check("rst_mid_pc", dut.pc, 32'h0);
        check("rst_mid_x1", dut.regs[1], 32'h0);
        check("rst_mid_state", 32'(dut.state), 32'd0);
        rst = 1'b1;
        run(20);
        check("restart_store", dm_word(32'h2000), 32'h0000_0055);
        check("im_preserved", dut.IM1.i_SRAM.MEMORY[0][0], enc_i(32'h55, 0, 0, 1, 7'h13));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv32_top.md
# rv32_top

Top-level processor block: a multi-cycle RV32I core with two word-addressed SRAM macros, one for instructions and one for data. It has no functional ports besides clock and reset. Before reset is released, both memories are back-door loaded with the same program image. Programs report results by storing to data memory, and signal completion by writing 0xFFFFFFFF to data word 0x3FFF.

## Interface
- No parameters. Memory geometry is fixed at 16384 × 32-bit words per memory.
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset (asserted = 0), sampled on the rising edge of clk.

## Operation
- **Memories**
  - Instances IM1 (instruction memory) and DM1 (data memory).
  - Each contains an instance i_SRAM with array MEMORY[0:511][0:31] of 32-bit words.
  - Word w is stored at MEMORY[w>>5][w&31].
  - Word index = byte address [15:2]; byte address bits [31:16] are ignored, so accesses wrap at 64 KiB.
  - Read is synchronous: data is valid the cycle after the address is presented.
  - Write uses a 32-bit active-low bit-write mask.
- **Program start:** PC resets to 0x0000_0000.
- **Instruction set:** full RV32I integer set, executed in order, one instruction at a time.
  - LUI, AUIPC, JAL, JALR (target bit0 cleared).
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LB, LH, LW, LBU, LHU.
  - SB, SH, SW.
  - All OP-IMM and OP ALU operations; shift amounts use bits [4:0].
- **Loads and stores:**
  - Sub-word loads extract the lane selected by addr[1:0] and sign- or zero-extend it.
  - Stores drive write data replicated into the lane and mask only the addressed byte or halfword.
  - Misaligned halfword/word accesses are not supported: low address bits are ignored for word access; a halfword uses addr[1].
- **CSR reads (CSRRS with rs1 = x0):**
  - 0xC00 / 0xC80: cycle counter, low / high word.
  - 0xC02 / 0xC82: instret counter, low / high word.
  - Any other CSR reads as 0. CSR writes are ignored.
- **Ignored opcodes:** FENCE, ECALL, EBREAK and any unrecognised opcode act as NOP (PC += 4).
- **Registers:** x0 reads 0 and ignores writes.
- **Counters:**
  - cycle increments every clock while rst = 1.
  - instret increments once per completed instruction, NOPs included.
- **State machine:** IF → ID → EX → (MEM → WB for loads | MEM for stores | WB otherwise) → IF.
  - IF: present PC to IM1.
  - ID: latch instruction from IM1 output and read rs1/rs2.
  - EX: ALU operation, branch compare, next-PC computation.
  - MEM: present address, data and mask to DM1.
  - WB: write rd, update PC.
- **No halt:** the core never stops. Programs end with a self-loop.

## Timing
- **Reset** (rst = 0 at a rising edge):
  - PC = 0, state = IF, all 32 registers = 0, cycle = 0, instret = 0.
  - No memory write is issued.
  - Memory contents are preserved.
- **Mid-operation reset:** reset asserted at any point aborts the current instruction. A store whose MEM cycle coincides with the reset edge must not write.
- **Latency per instruction:**
  - ALU / branch / jump / CSR: 4 cycles (IF, ID, EX, WB).
  - Store: 4 cycles (IF, ID, EX, MEM).
  - Load: 5 cycles (IF, ID, EX, MEM, WB).
- **Memory interface:**
  - IM1 is enabled only in IF.
  - DM1 is enabled only in MEM of a load or store.
  - Write is enabled only for stores.
- **Arithmetic:** 32-bit, with wrap-around. SRA/SRAI sign-fill; SLT/SLTI are signed; SLTU/SLTIU are unsigned.
- **Branches:** a taken branch targets PC + imm; a not-taken branch goes to PC + 4. Both update PC at the end of WB.

## Structure
- **Package rv32_pkg:**
  - Opcode constants, ALU operation enum and FSM state enum.
  - CSR address constants.
  - Memory depth constant 16384.
- **Sub-module SRAM_wrapper:** instantiated as IM1 and DM1, each containing i_SRAM.
  - Ports: CEB (active-low enable), WEB (active-low write), BWEB[31:0], A[13:0], DI[31:0], DO[31:0].
- All decode, ALU and register-file logic stays inside rv32_top.

## Test plan
- **Reset and first fetch:** hold rst = 0 for 2 cycles with IM word 0 = ADDI x1,x0,5 → after release and 4 cycles, x1 = 5 and PC = 4.
- **Store/load round-trip:** x2 = 0x8000, x3 = 0x8765_4321, SW x3,0(x2) → DM word 0x2000 = 0x87654321. Then:
  - LB from 0x8003 gives 0xFFFF_FF87.
  - LHU from 0x8002 gives 0x0000_8765.
  - SB of 0xAA at 0x8001 leaves the word as 0x8765_AA21.
- **Branches:** BLT with x1 = −1, x2 = 1 is taken; BLTU with the same operands is not taken; JALR to 0x0000_0103 lands at 0x102 with rd = PC + 4.
- **End code:** a program stores results at words 0x2000.. and then SW −1 to byte 0xFFFC → DM word 0x3FFF = 0xFFFFFFFF, and the results match the golden values.
- **Counters:** rdcycle executed twice back-to-back differs by 4; rdinstret increments by 1 per instruction; rdcycleh reads 0 in short runs.
- **x0 and reset:** ADDI x0,x0,7 leaves x0 = 0. Asserting rst during a store's MEM cycle leaves the target word unchanged and restarts at PC 0.
